run_detect_arbiter: RTL and testbench

- Shares one serial run-of-three detector between two requesters, round-robin.
- Detector flags three consecutive identical bits, either 111 or 000.
- Latches the granted requester's word and shifts it MSB-first through the detector, one bit per clock.
- Reports the match count, the position of the first match and the requester id to the datapath, which consumes per-word pattern statistics.

---
 rtl/run_detect_arbiter_pkg.sv | 26 ++
 rtl/run_detect_arbiter_if.sv | 28 ++
 rtl/run_detect_arbiter_run3_detector.sv | 52 +++++
 rtl/run_detect_arbiter.sv | 122 ++++++++++++
 tb/tb_run_detect_arbiter.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/run_detect_arbiter_pkg.sv
// Shared encodings for the run-of-three arbiter: top FSM states, detector
// run states and the found/not-found flag values.
package run_detect_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SCAN = 2'b01,
    DONE = 2'b10
  } arb_state_t;

  localparam logic FOUND    = 1'b1;
  localparam logic NOTFOUND = 1'b0;

  typedef enum logic [2:0] {
    D_START = 3'd0,
    D_ID1   = 3'd1,
    D_ID11  = 3'd2,
    D_ID0   = 3'd3,
    D_ID00  = 3'd4
  } run_state_t;

  function automatic logic [1:0] onehot_id(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/run_detect_arbiter_if.sv
// Request/grant and result bus between the two requesters/datapath and the
// shared run detector.
interface run_detect_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4,
  parameter int POS_W = 3
);
  logic [1:0]       req;
  logic [WIDTH-1:0] data0;
  logic [WIDTH-1:0] data1;
  logic [1:0]       gnt;
  logic             busy;
  logic             done;
  logic             done_id;
  logic             found;
  logic [CNT_W-1:0] match_count;
  logic [POS_W-1:0] first_pos;

  modport master (
    output req, data0, data1,
    input  gnt, busy, done, done_id, found, match_count, first_pos
  );

  modport slave (
    input  req, data0, data1,
    output gnt, busy, done, done_id, found, match_count, first_pos
  );
endinterface

// File: rtl/run_detect_arbiter_run3_detector.sv
// Serial detector for three equal consecutive bits (111 or 000); a match
// consumes the run so matches never overlap.
module run3_detector
  import run_detect_arbiter_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic valid,
  input  logic bit_in,
  output logic match
);

  run_state_t rs, rs_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rs <= D_START;
    else       rs <= rs_nxt;
  end

  always_comb begin
    rs_nxt = rs;
    match  = 1'b0;
    if (clear) begin
      rs_nxt = D_START;
    end else if (valid) begin
      case (rs)
        D_START: rs_nxt = bit_in ? D_ID1 : D_ID0;
        D_ID1:   rs_nxt = bit_in ? D_ID11 : D_ID0;
        D_ID0:   rs_nxt = bit_in ? D_ID1 : D_ID00;
        D_ID11: begin
          if (bit_in) begin
            match  = 1'b1;
            rs_nxt = D_START;
          end else begin
            rs_nxt = D_ID0;
          end
        end
        D_ID00: begin
          if (!bit_in) begin
            match  = 1'b1;
            rs_nxt = D_START;
          end else begin
            rs_nxt = D_ID1;
          end
        end
        default: rs_nxt = D_START;
      endcase
    end
  end

endmodule

// File: rtl/run_detect_arbiter.sv
// Round-robin arbiter sharing one run3_detector between two requesters;
// scans the granted word MSB-first and publishes per-word match statistics.
module run_detect_arbiter
  import run_detect_arbiter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4,
  parameter int POS_W = 3
) (
  input logic              clk,
  input logic              reset,
  run_detect_arbiter_if.slave bus
);

  localparam logic [POS_W-1:0] KMAX = POS_W'(WIDTH - 1);

  arb_state_t       state, state_nxt;
  logic             last;
  logic             cur_id;
  logic [WIDTH-1:0] sr;
  logic [POS_W-1:0] k;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [POS_W-1:0] fpos, fpos_nxt;
  logic             seen, seen_nxt;
  logic             accept;
  logic             win_id;
  logic [1:0]       gnt_c;
  logic             match;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // gnt is gated by reset so an asserted reset can never show a grant
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    win_id    = 1'b0;
    gnt_c     = 2'b00;
    case (state)
      IDLE: begin
        if (bus.req != 2'b00 && !reset) begin
          accept    = 1'b1;
          win_id    = (bus.req == 2'b10) || (bus.req == 2'b11 && !last);
          gnt_c     = onehot_id(win_id);
          state_nxt = SCAN;
        end
      end
      SCAN:    if (k == KMAX) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.gnt  = gnt_c;
  assign bus.busy = (state == SCAN);
  assign bus.done = (state == DONE);

  run3_detector u_det (
    .clk    (clk),
    .reset  (reset),
    .clear  (state == IDLE),
    .valid  (state == SCAN),
    .bit_in (sr[WIDTH-1]),
    .match  (match)
  );

  always_comb begin
    cnt_nxt  = cnt;
    fpos_nxt = fpos;
    seen_nxt = seen | match;
    if (match && cnt != {CNT_W{1'b1}}) cnt_nxt = cnt + CNT_W'(1);
    if (match && !seen)                fpos_nxt = k;
  end

  // Results are taken from the *_nxt values so the final bit's match counts
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last            <= 1'b1;
      cur_id          <= 1'b0;
      sr              <= '0;
      k               <= '0;
      cnt             <= '0;
      fpos            <= '0;
      seen            <= 1'b0;
      bus.done_id     <= 1'b0;
      bus.found       <= NOTFOUND;
      bus.match_count <= '0;
      bus.first_pos   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            last   <= win_id;
            cur_id <= win_id;
            sr     <= win_id ? bus.data1 : bus.data0;
            k      <= '0;
            cnt    <= '0;
            fpos   <= '0;
            seen   <= 1'b0;
          end
        end
        SCAN: begin
          sr   <= {sr[WIDTH-2:0], 1'b0};
          k    <= k + POS_W'(1);
          cnt  <= cnt_nxt;
          fpos <= fpos_nxt;
          seen <= seen_nxt;
          if (k == KMAX) begin
            bus.done_id     <= cur_id;
            bus.found       <= seen_nxt ? FOUND : NOTFOUND;
            bus.match_count <= cnt_nxt;
            bus.first_pos   <= fpos_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_run_detect_arbiter.sv
// Directed self-checking bench for run_detect_arbiter (WIDTH=8).
module tb_run_detect_arbiter;
  import run_detect_arbiter_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  run_detect_arbiter_if #(.WIDTH(8), .CNT_W(4), .POS_W(3)) bus ();

  run_detect_arbiter #(.WIDTH(8), .CNT_W(4), .POS_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_res(input string tag, input logic id, input logic f,
                         input logic [3:0] c, input logic [2:0] p);
    chk({tag, "_id"},    32'(bus.done_id),     32'(id));
    chk({tag, "_found"}, 32'(bus.found),       32'(f));
    chk({tag, "_count"}, 32'(bus.match_count), 32'(c));
    chk({tag, "_pos"},   32'(bus.first_pos),   32'(p));
  endtask

  // One full transaction from the IDLE acceptance cycle to the cycle after DONE.
  // pulse_k > 0 raises req=10 for one cycle during that SCAN cycle.
  task automatic run_txn(input string tag, input logic [1:0] rq,
                         input logic [7:0] d0, input logic [7:0] d1,
                         input logic id, input logic f,
                         input logic [3:0] c, input logic [2:0] p,
                         input int pulse_k);
    @(negedge clk);
    bus.req = rq; bus.data0 = d0; bus.data1 = d1;
    #1;
    chk({tag, "_gnt"},       32'(bus.gnt),  32'(onehot_id(id)));
    chk({tag, "_busy_idle"}, 32'(bus.busy), 32'd0);
    @(negedge clk);
    bus.req = 2'b00; bus.data0 = ~d0; bus.data1 = ~d1;
    #1;
    chk({tag, "_gnt_once"}, 32'(bus.gnt),  32'd0);
    chk({tag, "_busy"},     32'(bus.busy), 32'd1);
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      #1;
      chk({tag, "_busy"},      32'(bus.busy), 32'd1);
      chk({tag, "_done_early"}, 32'(bus.done), 32'd0);
      bus.req = (i == pulse_k) ? 2'b10 : 2'b00;
    end
    @(negedge clk);
    #1;
    chk({tag, "_done"},      32'(bus.done), 32'd1);
    chk({tag, "_busy_done"}, 32'(bus.busy), 32'd0);
    chk_res(tag, id, f, c, p);
    @(negedge clk);
    #1;
    chk({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
    chk_res({tag, "_hold"}, id, f, c, p);
  endtask

  initial begin
    reset = 1'b1;
    bus.req = 2'b00; bus.data0 = '0; bus.data1 = '0;
    #2;
    chk("rst_gnt",  32'(bus.gnt),  32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk_res("rst", 1'b0, 1'b0, 4'd0, 3'd0);
    @(negedge clk);
    reset = 1'b0;

    run_txn("t_e3",   2'b01, 8'b11100011, 8'h00,        1'b0, 1'b1, 4'd2, 3'd2, 0);
    run_txn("t_alt",  2'b10, 8'h00,       8'b10101010,  1'b1, 1'b0, 4'd0, 3'd0, 0);

    // Both requesting: last=1 so order 0,1,0,1 with grants 10 cycles apart
    @(negedge clk);
    bus.req = 2'b11; bus.data0 = 8'b00100010; bus.data1 = 8'b01110000;
    for (int c = 0; c <= 40; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 31) bus.req = 2'b00;
      #1;
      if (c % 10 == 0 && c < 40)
        chk("rr_gnt", 32'(bus.gnt), 32'(((c / 10) % 2 == 1) ? 2'b10 : 2'b01));
      else
        chk("rr_nognt", 32'(bus.gnt), 32'd0);
      if (c % 10 == 9) begin
        chk("rr_done", 32'(bus.done), 32'd1);
        if ((c / 10) % 2 == 0) chk_res("rr0", 1'b0, 1'b1, 4'd1, 3'd5);
        else                   chk_res("rr1", 1'b1, 1'b1, 4'd2, 3'd3);
      end
    end

    run_txn("t_ff", 2'b01, 8'hFF, 8'h00, 1'b0, 1'b1, 4'd2, 3'd2, 0);
    run_txn("t_00", 2'b01, 8'h00, 8'hFF, 1'b0, 1'b1, 4'd2, 3'd2, 0);

    // Reset during SCAN cycle 4 aborts the word and clears all results
    @(negedge clk);
    bus.req = 2'b01; bus.data0 = 8'hFF; bus.data1 = 8'b01110000;
    #1;
    chk("ab_gnt", 32'(bus.gnt), 32'd1);
    @(negedge clk);
    bus.req = 2'b00;
    repeat (3) @(negedge clk);
    #1;
    chk("ab_busy", 32'(bus.busy), 32'd1);
    reset = 1'b1; bus.req = 2'b10;
    #1;
    chk("ab_gnt_rst",  32'(bus.gnt),  32'd0);
    chk("ab_busy_rst", 32'(bus.busy), 32'd0);
    chk("ab_done_rst", 32'(bus.done), 32'd0);
    chk_res("ab_rst", 1'b0, 1'b0, 4'd0, 3'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      chk("ab_nodone", 32'(bus.done), 32'd0);
      chk("ab_nognt",  32'(bus.gnt),  32'd0);
    end
    reset = 1'b0;
    #1;
    chk("ab_gnt_after", 32'(bus.gnt), 32'd2);
    @(negedge clk);
    bus.req = 2'b00;
    #1;
    chk("ab_busy_after", 32'(bus.busy), 32'd1);
    repeat (8) @(negedge clk);
    #1;
    chk("ab_done_after", 32'(bus.done), 32'd1);
    chk_res("ab_after", 1'b1, 1'b1, 4'd2, 3'd3);

    // last=1 after the post-reset grant, so a joint request goes to 0
    run_txn("t_rr_rst", 2'b11, 8'b11100011, 8'hFF, 1'b0, 1'b1, 4'd2, 3'd2, 0);

    // One-cycle req pulse while busy must be ignored
    run_txn("t_pulse", 2'b10, 8'h00, 8'b11011000, 1'b1, 1'b1, 4'd1, 3'd7, 3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("pl_nognt", 32'(bus.gnt),  32'd0);
      chk("pl_idle",  32'(bus.busy), 32'd0);
      chk_res("pl_hold", 1'b1, 1'b1, 4'd1, 3'd7);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
